// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
// Module : datapath_pkg
// Shared nibble width, serial-adder state encoding and nibble-count helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package datapath_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } nsa_state_t;

   function automatic int nib_count(input int width);
      return width / NIB_W;
   endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_serial_adder_add4.sv
// ============================================================================
// Module : nibble_add4
// Combinational 4-bit Han-Carlson adder slice with carry-in.
// Optional carry-into-bit-3 output when NSA_OVERFLOW_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nibble_add4
   import datapath_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] s,
   output logic             cout
`ifdef NSA_OVERFLOW_EN
   ,output logic            c3
`endif
);

   logic [NIB_W-1:0] w_g;
   logic [NIB_W-1:0] w_p;
   logic             w_g0c;
   logic             w_g10;
   logic             w_p32;
   logic             w_g32;
   logic             w_g20;
   logic             w_g30;
   logic [NIB_W-1:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Carry-in is folded into bit 0's generate so the prefix tree is unchanged.
   assign w_g0c = w_g[0] | (w_p[0] & cin);

   // Odd positions first, then the even position picks up the odd result.
   assign w_g10 = w_g[1] | (w_p[1] & w_g0c);
   assign w_g32 = w_g[3] | (w_p[3] & w_g[2]);
   assign w_p32 = w_p[3] & w_p[2];
   assign w_g30 = w_g32 | (w_p32 & w_g10);
   assign w_g20 = w_g[2] | (w_p[2] & w_g10);

   assign w_c  = {w_g20, w_g10, w_g0c, cin};
   assign s    = w_p ^ w_c;
   assign cout = w_g30;

`ifdef NSA_OVERFLOW_EN
   assign c3 = w_g20;
`endif

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module : nibble_serial_adder
// Multi-cycle WIDTH-bit adder, one nibble per cycle, valid/ready on both sides.
// Optional signed-overflow output when NSA_OVERFLOW_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder
   import datapath_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef NSA_OVERFLOW_EN
   ,output logic            out_ovf
`endif
);

   localparam int NIB   = nib_count(WIDTH);
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NIB - 1);

   generate
      if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_width_check
         $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
      end
   endgenerate

   nsa_state_t        r_state;
   nsa_state_t        w_state_nxt;
   logic [WIDTH-1:0]  r_a_sh;
   logic [WIDTH-1:0]  r_b_sh;
   logic              r_carry;
   logic [CNT_W-1:0]  r_cnt;
   logic [NIB_W-1:0]  w_s;
   logic              w_cout;
   logic              w_accept;
   logic              w_last;
`ifdef NSA_OVERFLOW_EN
   logic              w_c3;
`endif

   nibble_add4 u_add4 (
      .a    (r_a_sh[NIB_W-1:0]),
      .b    (r_b_sh[NIB_W-1:0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_cout)
`ifdef NSA_OVERFLOW_EN
      ,.c3  (w_c3)
`endif
   );

   assign in_ready = ~rst & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
   assign w_accept = in_valid & in_ready;
   assign w_last   = (r_state == RUN) && (r_cnt == c_cnt_last);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = RUN;
         RUN:     if (r_cnt == c_cnt_last) w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = in_valid ? RUN : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_a_sh    <= '0;
         r_b_sh    <= '0;
         r_carry   <= 1'b0;
         r_cnt     <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
         out_ovf   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;

         if (r_state == DONE && out_ready)
            out_valid <= 1'b0;

         if (w_accept) begin
            r_a_sh  <= in_a;
            r_b_sh  <= in_b;
            r_carry <= in_cin;
            r_cnt   <= '0;
         end else if (r_state == RUN) begin
            // Nibbles enter at the top so nibble 0 lands at the bottom after NIB shifts.
            r_a_sh  <= r_a_sh >> NIB_W;
            r_b_sh  <= r_b_sh >> NIB_W;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
            out_sum <= {w_s, out_sum[WIDTH-1:NIB_W]};
            if (w_last) begin
               out_valid <= 1'b1;
               out_cout  <= w_cout;
`ifdef NSA_OVERFLOW_EN
               out_ovf   <= w_c3 ^ w_cout;
`endif
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module : tb_nibble_serial_adder
// Directed self-checking bench for nibble_serial_adder (WIDTH=16).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_cout;
`ifdef NSA_OVERFLOW_EN
   logic        out_ovf;
`endif

   int errors = 0;
   int checks = 0;
   int lat;

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
`ifdef NSA_OVERFLOW_EN
      ,.out_ovf  (out_ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a pair for one accepting edge, then scramble the inputs.
   task automatic start(input logic [15:0] a, input logic [15:0] b, input logic cin);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      tick();
      in_valid = 1'b0;
      in_a     = ~a;
      in_b     = ~b;
      in_cin   = ~cin;
   endtask

   task automatic wait_valid();
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic cin, input logic [15:0] esum, input logic ecout);
      start(a, b, cin);
      chk({tag, "_busy"}, {31'd0, out_valid}, 32'd0);
      wait_valid();
      chk({tag, "_lat"}, lat, 32'd4);
      chk({tag, "_sum"}, {16'd0, out_sum}, {16'd0, esum});
      chk({tag, "_cout"}, {31'd0, out_cout}, {31'd0, ecout});
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
      chk("rst_out_cout", {31'd0, out_cout}, 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
      tick();
      chk("basic_clr", {31'd0, out_valid}, 32'd0);
      chk("basic_hold", {16'd0, out_sum}, 32'h5555);
      chk("basic_ready", {31'd0, in_ready}, 32'd1);

      op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      tick();
      op("cin_chain", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
      tick();
      op("mixed", 16'hBEEF, 16'h1234, 1'b1, 16'hD124, 1'b0);
      tick();
      op("top_carry", 16'h8001, 16'h8000, 1'b1, 16'h0002, 1'b1);
      tick();

      out_ready = 1'b0;
      op("bp", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_sum", {16'd0, out_sum}, 32'h0100);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("bp_release_clr", {31'd0, out_valid}, 32'd0);

      // Back-to-back with in_valid held high.
      in_valid = 1'b1;
      in_a = 16'd1; in_b = 16'd2; in_cin = 1'b0;
      tick();
      in_a = 16'd3; in_b = 16'd4;
      wait_valid();
      chk("b2b0_lat", lat, 32'd4);
      chk("b2b0_sum", {16'd0, out_sum}, 32'd3);
      tick();
      chk("b2b1_clr", {31'd0, out_valid}, 32'd0);
      in_a = 16'd5; in_b = 16'd6;
      wait_valid();
      chk("b2b1_gap", lat + 1, 32'd5);
      chk("b2b1_sum", {16'd0, out_sum}, 32'd7);
      tick();
      in_valid = 1'b0;
      in_a = 16'hAAAA; in_b = 16'h5555;
      wait_valid();
      chk("b2b2_gap", lat + 1, 32'd5);
      chk("b2b2_sum", {16'd0, out_sum}, 32'd11);
      tick();
      chk("b2b2_clr", {31'd0, out_valid}, 32'd0);

      // Reset two cycles into an operation.
      start(16'h1111, 16'h2222, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_sum", {16'd0, out_sum}, 32'd0);
      chk("mid_rst_cout", {31'd0, out_cout}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_rst_novalid", {31'd0, out_valid}, 32'd0);
      end

`ifdef NSA_OVERFLOW_EN
      op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
      chk("ovf_pos_flag", {31'd0, out_ovf}, 32'd1);
      tick();
      op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
      chk("ovf_neg_flag", {31'd0, out_ovf}, 32'd1);
      tick();
      op("ovf_none", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
      chk("ovf_none_flag", {31'd0, out_ovf}, 32'd0);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
